// File: rtl/instr_loader.sv
// instr_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory.
module instr_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter bit         STRICT_HI = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [8:0] count
);
    typedef enum logic [2:0] {IDLE, LEN, LO, HI, WRITE, CHK, DONE, ERR} state_t;
    state_t state, state_nxt;
    logic [8:0] n;
    logic [7:0] lo, chk, idx;
    logic acc, restart;
    assign in_ready = state == LEN || state == LO || state == HI || state == CHK;
    assign busy     = in_ready || state == WRITE;
    assign wr_en    = state == WRITE;
    assign done     = state == DONE;
    assign error    = state == ERR;
    assign acc      = in_valid && in_ready;
    assign restart  = start && (state == IDLE || state == DONE || state == ERR);
    always_comb begin
        state_nxt = state;
        if (restart) state_nxt = LEN;
        else begin
            case (state)
                LEN:     state_nxt = acc ? LO : LEN;
                LO:      state_nxt = acc ? HI : LO;
                HI:      state_nxt = !acc ? HI : (STRICT_HI && |in_data[7:1]) ? ERR : WRITE;
                WRITE:   state_nxt = (count + 9'd1 == n) ? CHK : LO;
                CHK:     state_nxt = !acc ? CHK : (in_data == chk) ? DONE : ERR;
                default: state_nxt = state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n       <= '0;
            lo      <= '0;
            chk     <= '0;
            idx     <= '0;
            count   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                chk   <= '0;
                idx   <= '0;
                count <= '0;
            end else if (acc) begin
                chk <= chk ^ in_data;
                // a length byte of zero encodes 256 instructions
                if (state == LEN) n <= {in_data == 8'd0, in_data};
                if (state == LO) lo <= in_data;
                if (state == HI) begin
                    wr_addr <= BASE_ADDR + idx;
                    wr_data <= {in_data[0], lo};
                end
            end else if (state == WRITE) begin
                idx   <= idx + 8'd1;
                count <= count + 9'd1;
            end
        end
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: BASE_ADDR, 8'h00, first instruction-memory address written.
REQ-002 Parameter: STRICT_HI, 1, when 1 a high byte with nonzero bits [7:1] is a format error.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_data  input  8  byte stream: length, instruction bytes, checksum.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
REQ-009 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 wr_addr  output  8  instruction-memory write address.
REQ-011 wr_data  output  9  instruction word to write.
REQ-012 busy  output  1  load in progress; the processor is held while high.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 error  output  1  last load aborted on format error or checksum mismatch.
REQ-015 count  output  9  instructions written in the current/last load (0..256).

Function
REQ-016 States: IDLE, LEN, LO, HI, WRITE, CHK, DONE, ERR.
REQ-017 in_ready SHALL be 1 only in LEN, LO, HI and CHK; the loader consumes no byte while in_ready=0.
REQ-018 busy SHALL be 1 exactly in LEN, LO, HI, WRITE and CHK.
REQ-019 On accepted start: next state LEN; done, error, count, index and checksum cleared to 0 in the same edge.
REQ-020 LEN: accepted byte sets N = in_data, with 0 meaning 256; checksum ^= byte; next state LO.
REQ-021 LO: accepted byte latched as low byte; checksum ^= byte; next state HI.
REQ-022 HI: accepted byte -> checksum ^= byte; if STRICT_HI=1 and in_data[7:1]!=0, next state ERR with no write; otherwise next state WRITE.
REQ-023 WRITE: wr_en=1 for exactly this one cycle; wr_addr = (BASE_ADDR + index) mod 256; wr_data = {hi[0], lo}; index and count increment.
REQ-024 From WRITE: next state CHK when count reaches N, otherwise LO.
REQ-025 CHK: accepted byte compared to running XOR; equal -> DONE; unequal -> ERR.
REQ-026 DONE holds done=1 and ERR holds error=1 until the next accepted start.
REQ-027 wr_en SHALL be 0 in every state except WRITE; wr_addr and wr_data are registered and stable while wr_en=1.
REQ-028 Peak throughput: one instruction per 3 cycles (LO, HI, WRITE) with in_valid held high.
REQ-029 in_valid low in an accepting state: the FSM stalls in place with no state or data change.
REQ-030 start outside IDLE, DONE and ERR is ignored.
REQ-031 Address wrap: BASE_ADDR + index wraps modulo 256 without error.
REQ-032 Words already written before an ERR remain written; no rollback.

Reset
REQ-033 While rst_n=0, immediately and independent of clk: state=IDLE; in_ready, wr_en, busy, done and error = 0; count, wr_addr and wr_data = 0.
REQ-034 Reset asserted mid-load abandons the load; it produces neither done nor error, and the next start begins a fresh load.

Verification
REQ-035 BASE_ADDR=0; start, then bytes 02,34,01,7F,00,48 -> writes 0x134@0x00 and 0x07F@0x01; done=1, error=0, count=2.
REQ-036 Same stream with checksum 0x49 -> both writes occur; error=1, done=0.
REQ-037 STRICT_HI=1; high byte 0x03 -> no wr_en for that instruction; error=1; busy=0 on the next cycle.
REQ-038 BASE_ADDR=0x80, length byte 00 (256 instructions) -> 256 writes, first address 0x80, last address 0x7F; count=256; done=1.
REQ-039 rst_n pulsed low during HI of instruction 2 -> wr_en, busy and done drop to 0 without a clock edge; a subsequent full load completes correctly.
REQ-040 in_valid randomly deasserted during a 4-instruction load -> identical writes and checksum result to the gap-free run; no byte is consumed while in_ready=0.
